// File: rtl/matriz_sequenciador.sv
// Front-end sequencer for the matrix arithmetic unit: loads A/B serially,
// launches one operation, captures the result and streams it back out.
module matriz_sequenciador #(
  parameter int N_ELEM  = 25,
  parameter int ELEM_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [4:0]                 in_index,
  input  logic [ELEM_W-2:0]          in_data,
  input  logic                       clr,
  input  logic                       go,
  input  logic [2:0]                 op_in,
  output logic                       busy,
  output logic                       err,
  output logic                       start,
  output logic [2:0]                 operacao,
  output logic [N_ELEM*ELEM_W-1:0]   matriz_A,
  output logic [N_ELEM*ELEM_W-1:0]   matriz_B,
  input  logic [N_ELEM*ELEM_W-1:0]   matriz_resultado,
  input  logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_index,
  output logic [ELEM_W-1:0]          out_data,
  output logic                       out_last
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, STREAM} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         count;
  logic [4:0]               k;
  logic [N_ELEM*ELEM_W-1:0] result_q;
  logic                     timeout_hit;
  logic                     wr_fire;

  assign wr_fire = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // start stays high through WAIT_DONE so the unit keeps seeing the request
  // until done; stale done from the previous run is ignored in LAUNCH
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    start       = 1'b0;
    out_valid   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (go) state_next = LAUNCH;
      end
      LAUNCH: begin
        start      = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        start = 1'b1;
        if (done) begin
          state_next = STREAM;
        end else if (count == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && k == LAST_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matriz_A <= '0;
      matriz_B <= '0;
      result_q <= '0;
      operacao <= 3'b000;
      err      <= 1'b0;
      count    <= '0;
      k        <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          k     <= '0;
          if (clr) begin
            matriz_A <= '0;
            matriz_B <= '0;
          end else if (wr_fire) begin
            for (int i = 0; i < N_ELEM; i++) begin
              if (in_index == 5'(i)) begin
                if (in_sel) matriz_B[i*ELEM_W +: ELEM_W] <= {1'b0, in_data};
                else        matriz_A[i*ELEM_W +: ELEM_W] <= {1'b0, in_data};
              end
            end
          end
          if (go) begin
            operacao <= op_in;
            err      <= 1'b0;
          end
          // a bad index still completes its handshake but flags the host
          if (wr_fire && in_index > LAST_IDX) err <= 1'b1;
        end
        LAUNCH: count <= '0;
        WAIT_DONE: begin
          if (done)             result_q <= matriz_resultado;
          else if (timeout_hit) err      <= 1'b1;
          else                  count    <= count + 1'b1;
        end
        STREAM: begin
          if (out_ready && k != LAST_IDX) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (state == STREAM && k == 5'(i)) out_data = result_q[i*ELEM_W +: ELEM_W];
    end
  end

  assign out_index = k;
  assign out_last  = (state == STREAM) && (k == LAST_IDX);

endmodule

// File: tb/tb_matriz_sequenciador.sv
// Directed bench for matriz_sequenciador with a small behavioural model of
// the arithmetic unit (slot-wise 9-bit add/sub, done held until next start).
module tb_matriz_sequenciador;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sel;
  logic [4:0]   in_index;
  logic [7:0]   in_data;
  logic         clr, go;
  logic [2:0]   op_in;
  logic         busy, err, start;
  logic [2:0]   operacao;
  logic [224:0] matriz_A, matriz_B, matriz_resultado;
  logic         done;
  logic         out_valid, out_ready;
  logic [4:0]   out_index;
  logic [8:0]   out_data;
  logic         out_last;

  logic         unit_en = 1'b1;
  logic         unit_done = 1'b0;
  logic [224:0] unit_res = '0;

  int           n_total = 0;
  int           n_pass = 0;
  logic [8:0]   got [25];

  always #5 clk = ~clk;

  matriz_sequenciador dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_index(in_index), .in_data(in_data), .clr(clr),
    .go(go), .op_in(op_in), .busy(busy), .err(err), .start(start),
    .operacao(operacao), .matriz_A(matriz_A), .matriz_B(matriz_B),
    .matriz_resultado(matriz_resultado), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .out_last(out_last)
  );

  function automatic logic [224:0] unitCalc(input logic [224:0] a, input logic [224:0] b,
                                             input logic [2:0] op);
    logic [224:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      case (op)
        3'b000:  r[i*9 +: 9] = a[i*9 +: 9] + b[i*9 +: 9];
        3'b001:  r[i*9 +: 9] = a[i*9 +: 9] - b[i*9 +: 9];
        default: r[i*9 +: 9] = 9'd0;
      endcase
    end
    return r;
  endfunction

  // The unit refreshes its result whenever it sees start and then holds done
  always @(posedge clk) begin
    if (start) begin
      unit_done <= 1'b1;
      unit_res  <= unitCalc(matriz_A, matriz_B, operacao);
    end
  end
  assign done             = unit_en & unit_done;
  assign matriz_resultado = unit_res;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    n_total++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic sel, input logic [4:0] idx, input logic [7:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = sel;
    in_index = idx;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pulses go, then counts start-high cycles until the first out_valid or idle
  task automatic runOp(input logic [2:0] op, output int start_cyc, output int lat,
                       output logic saw_valid);
    @(negedge clk);
    go    = 1'b1;
    op_in = op;
    @(negedge clk);
    go        = 1'b0;
    lat       = 1;
    start_cyc = 0;
    saw_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (start) start_cyc++;
      if (out_valid) begin
        saw_valid = 1'b1;
        break;
      end
      if (!busy) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic collectStream(output int n, output logic seq_ok);
    n         = 0;
    seq_ok    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && n < 25; c++) begin
      if (out_valid) begin
        if (out_index != 5'(n)) seq_ok = 1'b0;
        if (out_last != (n == 24)) seq_ok = 1'b0;
        got[n] = out_data;
        n++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  function automatic logic othersZero(input int skip_a, input int skip_b);
    logic z;
    z = 1'b1;
    for (int i = 0; i < 25; i++)
      if (i != skip_a && i != skip_b && got[i] != 9'd0) z = 1'b0;
    return z;
  endfunction

  initial begin
    int           sc, lat, n;
    logic         sv, ok, stable, found;
    logic [224:0] saved_a, saved_b;
    logic [8:0]   d7;

    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_index = '0; in_data = '0;
    clr = 1'b0; go = 1'b0; op_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_matriz_A", matriz_A, 0);
    reset = 1'b0;

    // Run 1: add, single element
    applyStimulus(1'b0, 5'd0, 8'd5);
    applyStimulus(1'b1, 5'd0, 8'd3);
    checkOutput("packA0", matriz_A[8:0], 9'd5);
    checkOutput("packB0", matriz_B[8:0], 9'd3);
    runOp(3'b000, sc, lat, sv);
    checkOutput("r1_saw_valid", sv, 1);
    checkOutput("r1_start_cycles", sc, 2);
    checkOutput("r1_latency", lat, 3);
    checkOutput("r1_first_idx", out_index, 0);
    checkOutput("r1_first_data", out_data, 9'd8);
    collectStream(n, ok);
    checkOutput("r1_count", n, 25);
    checkOutput("r1_seq_last", ok, 1);
    checkOutput("r1_elem0", got[0], 9'd8);
    checkOutput("r1_others_zero", othersZero(0, 0), 1);
    checkOutput("r1_idle", busy, 0);

    // Run 2: subtract, back-to-back with done still high from run 1
    applyStimulus(1'b0, 5'd24, 8'hFF);
    applyStimulus(1'b1, 5'd24, 8'h01);
    checkOutput("packA24", matriz_A[224:216], 9'h0FF);
    checkOutput("packB24", matriz_B[224:216], 9'h001);
    runOp(3'b001, sc, lat, sv);
    checkOutput("r2_operacao", operacao, 3'b001);
    checkOutput("r2_start_cycles", sc, 2);
    collectStream(n, ok);
    checkOutput("r2_count", n, 25);
    checkOutput("r2_elem0_fresh", got[0], 9'd2);
    checkOutput("r2_elem24", got[24], 9'h0FE);
    checkOutput("r2_others_zero", othersZero(0, 24), 1);

    // Bad index: handshake completes, no slot changes, err sticky until go
    saved_a = matriz_A;
    saved_b = matriz_B;
    applyStimulus(1'b0, 5'd25, 8'hAA);
    checkOutput("bad_idx_A", matriz_A, saved_a);
    checkOutput("bad_idx_B", matriz_B, saved_b);
    checkOutput("bad_idx_err", err, 1);
    runOp(3'b000, sc, lat, sv);
    checkOutput("go_clears_err", err, 0);
    collectStream(n, ok);
    checkOutput("r3_elem24", got[24], 9'h100);

    // Timeout with done tied low
    unit_en = 1'b0;
    runOp(3'b000, sc, lat, sv);
    checkOutput("to_no_valid", sv, 0);
    checkOutput("to_start_cycles", sc, 256);
    checkOutput("to_err", err, 1);
    checkOutput("to_start_low", start, 0);
    checkOutput("to_idle", busy, 0);
    unit_en = 1'b1;

    // clr beats a simultaneous write
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_index = 5'd3; in_data = 8'd7;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checkOutput("clr_A", matriz_A, 0);
    checkOutput("clr_B", matriz_B, 0);

    // Stall at k=7, then reset at k=12
    applyStimulus(1'b0, 5'd7, 8'h10);
    applyStimulus(1'b1, 5'd7, 8'h22);
    runOp(3'b000, sc, lat, sv);
    checkOutput("r4_saw_valid", sv, 1);
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_index == 5'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("reach_k7", found, 1);
    d7     = out_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_index != 5'd7 || out_data != d7) stable = 1'b0;
    end
    checkOutput("stall_stable", stable, 1);
    checkOutput("stall_data7", d7, 9'h032);
    out_ready = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_index == 5'd12) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach_k12", found, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_start", start, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_index", out_index, 0);
    checkOutput("mid_rst_data", out_data, 0);
    checkOutput("mid_rst_operacao", operacao, 0);
    checkOutput("mid_rst_A", matriz_A, 0);
    checkOutput("mid_rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
